demux4_stream: RTL

- Registered 1-to-4 streaming demultiplexer. It steers one input word stream to one of four output channels (a/b/c/d), chosen by a 2-bit select.
- It is the inverse of the team's 4:1 16-bit mux.
- It sits between a single producer and four consumers. Every input and output carries a valid/ready handshake, and each channel has a one-entry output register so that back-pressure on one channel does not corrupt the others.

---
 rtl/demux4_stream.sv | 80 ++++++++
 1 files changed

// File: rtl/demux4_stream.sv
// Purpose: steers one valid/ready word stream to one of four channels, each with a one-entry output register.
// Latency: one cycle from input accept to channel valid.
// Backpressure: ready_o drops only when the selected channel is full and not draining this cycle; other channels are unaffected.
module demux4_stream #(
    parameter int Width      = 16,
    parameter int CountWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [1:0]            sel_i,
    input  logic [Width-1:0]      data_i,
    output logic [Width-1:0]      a_o,
    output logic [Width-1:0]      b_o,
    output logic [Width-1:0]      c_o,
    output logic [Width-1:0]      d_o,
    output logic                  a_valid_o,
    output logic                  b_valid_o,
    output logic                  c_valid_o,
    output logic                  d_valid_o,
    input  logic                  a_ready_i,
    input  logic                  b_ready_i,
    input  logic                  c_ready_i,
    input  logic                  d_ready_i,
    output logic [CountWidth-1:0] count_o
);

    // One output slot: occupancy flag plus the held word.
    typedef struct packed {
        logic             vld;
        logic [Width-1:0] dat;
    } chan_t;

    chan_t [3:0]           chan_q;
    logic  [3:0]           chan_rdy;
    logic                  accept;
    logic [CountWidth-1:0] count_q;

    // Index 0..3 maps to channels a..d, matching the sel_i encoding.
    assign chan_rdy = {d_ready_i, c_ready_i, b_ready_i, a_ready_i};

    // Accept when the target slot is empty or is being emptied this same cycle.
    always_comb begin
        ready_o = !rst_i && (!chan_q[sel_i].vld || chan_rdy[sel_i]);
        accept  = valid_i && ready_o;
    end

    // Slot update per channel: a fill wins over a drain, so a simultaneous drain+fill keeps the slot valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chan_q  <= '0;
            count_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (accept && (sel_i == 2'(k))) begin
                    chan_q[k].vld <= 1'b1;
                    chan_q[k].dat <= data_i;
                end else if (chan_q[k].vld && chan_rdy[k]) begin
                    // Data is left as-is after a drain; only the valid flag drops.
                    chan_q[k].vld <= 1'b0;
                end
            end
            if (accept) begin
                count_q <= count_q + CountWidth'(1);
            end
        end
    end

    assign a_o       = chan_q[0].dat;
    assign b_o       = chan_q[1].dat;
    assign c_o       = chan_q[2].dat;
    assign d_o       = chan_q[3].dat;
    assign a_valid_o = chan_q[0].vld;
    assign b_valid_o = chan_q[1].vld;
    assign c_valid_o = chan_q[2].vld;
    assign d_valid_o = chan_q[3].vld;
    assign count_o   = count_q;

endmodule
